// File: rtl/out_requant.sv
// out_requant: reads up to 8 rows of signed 16-bit results, requantizes each element
// to int8 (negatives to zero, logical right shift, saturate or truncate) and writes 8 packed rows.
module out_requant #(
    parameter int unsigned SAT_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] mnt,
    input  logic [3:0]  shift,
    output logic        en_o,
    output logic [3:0]  addr_o,
    input  logic [63:0] rdata_o,
    output logic        en_r,
    output logic        rw_r,
    output logic [2:0]  addr_r,
    output logic [63:0] wdata_r,
    output logic        done
);
    localparam int unsigned ROW_W  = 64;
    localparam int unsigned ELEM_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NCOL   = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned T_W    = 3;
    localparam int unsigned ADDR_W = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [T_W-1:0]      t_q, t_d;
    logic [CNT_W-1:0]    m_q, rows_q, shift_q;
    logic [ROW_W-1:0]    lo_q;

    logic                en_o_d, en_r_d, done_d;
    logic [ADDR_W-1:0]   addr_o_d;
    logic [T_W-1:0]      addr_r_d;
    logic [ROW_W-1:0]    wdata_r_d;

    // N field of mnt carries no meaning for this block
    logic unused_n;
    assign unused_n = ^mnt[7:4];

    function automatic logic [CNT_W-1:0] clamp8(input logic [CNT_W-1:0] v);
        clamp8 = (v > CNT_W'(8)) ? CNT_W'(8) : v;
    endfunction

    function automatic logic [BYTE_W-1:0] requant(input logic [ELEM_W-1:0] x,
                                                   input logic [CNT_W-1:0]  sh);
        logic [ELEM_W-1:0] r;
        logic [ELEM_W-1:0] y;
        r = x[ELEM_W-1] ? '0 : x;
        y = r >> sh;
        if (SAT_EN != 0)
            requant = (y > ELEM_W'(127)) ? BYTE_W'(127) : y[BYTE_W-1:0];
        else
            requant = y[BYTE_W-1:0];
    endfunction

    // Column j sits at the j-th 16-bit slot of {lo, hi}; columns beyond m are zeroed
    function automatic logic [ROW_W-1:0] pack(input logic [ROW_W-1:0] lo,
                                              input logic [ROW_W-1:0] hi,
                                              input logic [CNT_W-1:0] m,
                                              input logic [CNT_W-1:0] sh);
        logic [2*ROW_W-1:0] src;
        logic [ROW_W-1:0]   res;
        src = {lo, hi};
        res = '0;
        for (int j = 0; j < int'(NCOL); j++) begin
            if (CNT_W'(j) < m)
                res[ROW_W-1-BYTE_W*j -: BYTE_W] = requant(src[2*ROW_W-1-ELEM_W*j -: ELEM_W], sh);
        end
        pack = res;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    // Next-state and row counter
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                t_d = '0;
                if (start)
                    state_d = (clamp8(mnt[3:0]) != '0) ? S_RD0 : S_WR;
            end
            S_RD0:  state_d = S_RD1;
            S_RD1:  state_d = S_CAP;
            S_CAP:  state_d = S_WR;
            S_WR: begin
                if (t_q == T_W'(7)) begin
                    t_d     = '0;
                    state_d = S_DONE;
                end else begin
                    t_d     = T_W'(t_q + T_W'(1));
                    state_d = ({1'b0, t_d} < rows_q) ? S_RD0 : S_WR;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the upcoming state, registered below so they align with it
    always_comb begin
        en_o_d    = 1'b0;
        addr_o_d  = '0;
        en_r_d    = 1'b0;
        addr_r_d  = '0;
        wdata_r_d = '0;
        done_d    = 1'b0;
        case (state_d)
            S_RD0: begin
                en_o_d   = 1'b1;
                addr_o_d = {t_d, 1'b0};
            end
            S_RD1: begin
                en_o_d   = 1'b1;
                addr_o_d = {t_d, 1'b1};
            end
            S_WR: begin
                en_r_d   = 1'b1;
                addr_r_d = t_d;
                // High half arrives on rdata_o during CAP; skipped rows stay zero
                if (state_q == S_CAP)
                    wdata_r_d = pack(lo_q, rdata_o, m_q, shift_q);
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    // Latched parameters, low half and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q     <= '0;
            rows_q  <= '0;
            shift_q <= '0;
            lo_q    <= '0;
            en_o    <= 1'b0;
            addr_o  <= '0;
            en_r    <= 1'b0;
            rw_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            done    <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                m_q     <= clamp8(mnt[11:8]);
                rows_q  <= clamp8(mnt[3:0]);
                shift_q <= shift;
            end
            if (state_q == S_RD1)
                lo_q <= rdata_o;
            en_o    <= en_o_d;
            addr_o  <= addr_o_d;
            en_r    <= en_r_d;
            rw_r    <= en_r_d;
            addr_r  <= addr_r_d;
            wdata_r <= wdata_r_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_out_requant.sv
// Bench for out_requant: saturating and truncating instances share stimulus and a
// result-memory model; a reference model fills queues that a negedge monitor drains.
module tb_out_requant;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [11:0] mnt;
    logic [3:0]  shift;
    logic [63:0] rdata_o;
    logic        en_o, en_r, rw_r, done;
    logic [3:0]  addr_o;
    logic [2:0]  addr_r;
    logic [63:0] wdata_r;
    logic        en_o1, en_r1, rw_r1, done1;
    logic [3:0]  addr_o1;
    logic [2:0]  addr_r1;
    logic [63:0] wdata_r1;

    out_requant #(.SAT_EN(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mnt(mnt), .shift(shift),
        .en_o(en_o), .addr_o(addr_o), .rdata_o(rdata_o),
        .en_r(en_r), .rw_r(rw_r), .addr_r(addr_r), .wdata_r(wdata_r), .done(done));

    out_requant #(.SAT_EN(0)) dut_trunc (
        .clk(clk), .rst(rst), .start(start), .mnt(mnt), .shift(shift),
        .en_o(en_o1), .addr_o(addr_o1), .rdata_o(rdata_o),
        .en_r(en_r1), .rw_r(rw_r1), .addr_r(addr_r1), .wdata_r(wdata_r1), .done(done1));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [63:0] d_sat;
        logic [63:0] d_trunc;
    } wr_t;

    logic [63:0] mem [16];
    logic [3:0]  exp_rd [$];
    wr_t         exp_wr [$];
    int          exp_done [$];
    int          cyc = 0;
    int          start_cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Result memory: one-cycle read latency, junk when not enabled
    always @(posedge clk) rdata_o <= en_o ? mem[addr_o] : {$urandom(), $urandom()};

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] ref_byte(input int x, input int sh, input bit sat);
        int r;
        r = (x < 0) ? 0 : x;
        r = r / (1 << sh);
        if (sat) return (r > 127) ? 8'd127 : 8'(r);
        return 8'(r % 256);
    endfunction

    function automatic void push_exp(input logic [11:0] m12, input logic [3:0] sh);
        int mc, tc, k;
        wr_t w;
        logic [63:0] word;
        logic signed [15:0] e;
        mc = (int'(m12[11:8]) > 8) ? 8 : int'(m12[11:8]);
        tc = (int'(m12[3:0]) > 8) ? 8 : int'(m12[3:0]);
        for (int t = 0; t < 8; t++) begin
            w.addr = 3'(t);
            w.d_sat = '0;
            w.d_trunc = '0;
            if (t < tc) begin
                exp_rd.push_back(4'(2*t));
                exp_rd.push_back(4'(2*t+1));
                for (int j = 1; j <= mc; j++) begin
                    word = mem[2*t + ((j > 4) ? 1 : 0)];
                    k = (j - 1) % 4;
                    e = word[63-16*k -: 16];
                    w.d_sat[63-8*(j-1) -: 8]   = ref_byte(int'(e), int'(sh), 1'b1);
                    w.d_trunc[63-8*(j-1) -: 8] = ref_byte(int'(e), int'(sh), 1'b0);
                end
            end
            exp_wr.push_back(w);
        end
        exp_done.push_back(4*tc + (8 - tc) + 1);
    endfunction

    // Monitor: every memory access and DONE pulse must match the next expectation
    logic [3:0] a_pop;
    wr_t        w_pop;
    int         l_pop;
    always @(negedge clk) begin
        if (!rst) begin
            if (en_o || en_r) chk("en_exclusive", 64'(en_o & en_r), 64'd0);
            if (en_o || en_o1) begin
                if (exp_rd.size() == 0) chk("unexpected_read", 64'(addr_o), 64'hx);
                else begin
                    a_pop = exp_rd.pop_front();
                    chk("rd_en", 64'({en_o, en_o1}), 64'h3);
                    chk("rd_addr", 64'(addr_o), 64'(a_pop));
                    chk("rd_addr_trunc", 64'(addr_o1), 64'(a_pop));
                end
            end
            if (en_r || en_r1) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 64'(addr_r), 64'hx);
                else begin
                    w_pop = exp_wr.pop_front();
                    chk("wr_en_rw", 64'({en_r, en_r1, rw_r, rw_r1}), 64'hF);
                    chk("wr_addr", 64'(addr_r), 64'(w_pop.addr));
                    chk("wr_addr_trunc", 64'(addr_r1), 64'(w_pop.addr));
                    chk("wr_data_sat", wdata_r, w_pop.d_sat);
                    chk("wr_data_trunc", wdata_r1, w_pop.d_trunc);
                end
            end
            if (done || done1) begin
                if (exp_done.size() == 0) chk("unexpected_done", 64'(done), 64'hx);
                else begin
                    l_pop = exp_done.pop_front();
                    chk("done_both", 64'({done, done1}), 64'h3);
                    chk("done_latency", 64'(cyc - start_cyc + 1), 64'(l_pop));
                end
            end
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) mem[i] = {$urandom(), $urandom()};
    endtask

    task automatic issue(input logic [11:0] m, input logic [3:0] sh);
        push_exp(m, sh);
        @(negedge clk);
        mnt = m; shift = sh; start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        start = 1'b0;
        mnt = 12'($urandom());
        shift = 4'($urandom());
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_en_o"}, 64'({en_o, en_o1}), 64'd0);
        chk({tag, "_en_r_rw_r"}, 64'({en_r, en_r1, rw_r, rw_r1}), 64'd0);
        chk({tag, "_addr"}, 64'({addr_o, addr_r, addr_o1, addr_r1}), 64'd0);
        chk({tag, "_wdata"}, wdata_r | wdata_r1, 64'd0);
        chk({tag, "_done"}, 64'({done, done1}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; start = 1'b0; mnt = '0; shift = '0;
        fill_mem();
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Mixed signs and saturation, M=3 T=3
        fill_mem();
        mem[0] = 64'h0005_FFFF_0100_0000;
        issue(12'h373, 4'd0);
        wait_done();

        // Shift by 4, all columns
        fill_mem();
        mem[0] = {16'h07F0, 16'h0123, 16'h7FFF, 16'h0010};
        issue(12'h808, 4'd4);
        wait_done();

        // Truncate vs saturate on 0x0100 and 0x8000
        fill_mem();
        mem[0] = {16'h0100, 16'h8000, 16'h00FF, 16'h0080};
        mem[1] = {16'h1234, 16'hFF80, 16'h007F, 16'h0001};
        issue(12'h801, 4'd0);
        wait_done();

        // Full frame: reads 0..15, writes 0..7
        fill_mem();
        issue(12'h888, 4'd3);
        wait_done();

        // No valid rows; a mid-run START is ignored
        issue(12'h5A0, 4'd1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Fields above 8 clamp to 8; M=0 zeros all columns
        fill_mem();
        issue(12'hF0F, 4'd2);
        wait_done();
        fill_mem();
        issue(12'h005, 4'd0);
        wait_done();

        // START held through DONE retriggers from IDLE
        fill_mem();
        push_exp(12'h545, 4'd2);
        @(negedge clk);
        mnt = 12'h545; shift = 4'd2; start = 1'b1;
        @(posedge clk);
        #1 start_cyc = cyc;
        wait_done();
        push_exp(12'h545, 4'd2);
        @(posedge clk);
        @(posedge clk);
        #1 start_cyc = cyc;
        start = 1'b0;
        wait_done();

        // Reset during row-2 RD1 aborts the run
        fill_mem();
        issue(12'h888, 4'd1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = en_o && (addr_o == 4'd5);
        end
        if (!found) chk("abort_point_reached", 64'd0, 64'd1);
        #1 rst = 1'b1;
        #1 chk_idle_outputs("midrun_reset");
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(12'h373, 4'd0);
        wait_done();

        // Randomized runs
        for (int n = 0; n < 24; n++) begin
            fill_mem();
            issue(12'($urandom()), 4'($urandom_range(0, 8)));
            wait_done();
        end

        repeat (5) @(negedge clk);
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/out_requant.md
OUT_REQUANT -- requirements
Module: out_requant

Interface
REQ-001 SHALL have parameter SAT_EN, default 1, meaning 1 = saturate to 127 and 0 = truncate to the low 8 bits.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 CLK  in  1  clock, all state on rising edge.
REQ-004 RST  in  1  asynchronous active-high reset.
REQ-005 START  in  1  start request, sampled only in IDLE.
REQ-006 MNT  in  12  {M[11:8], N[7:4], T[3:0]}; N unused.
REQ-007 SHIFT  in  4  right-shift amount for requantization.
REQ-008 EN_O  out  1  result-memory (16x64) enable, read-only access.
REQ-009 ADDR_O  out  4  result-memory address.
REQ-010 RDATA_O  in  64  result-memory read data, valid the cycle after EN_O.
REQ-011 EN_R  out  1  requantized-memory (8x64) enable.
REQ-012 RW_R  out  1  1 = write; driven equal to EN_R.
REQ-013 ADDR_R  out  3  requantized-memory row address.
REQ-014 WDATA_R  out  64  packed int8 row.
REQ-015 DONE  out  1  one-cycle completion pulse.

Function
REQ-016 On START=1 in IDLE, SHALL latch MNT and SHIFT; later changes to them have no effect until the next start.
REQ-017 M and T SHALL be clamped: a value above 8 is treated as 8; a value of 0 means no valid columns or no valid rows.
REQ-018 States SHALL be IDLE, RD0, RD1, CAP, WR and DONE, with row counter t from 0 to 7.
REQ-019 From IDLE: if t<T, go to RD0; otherwise go to WR.
REQ-020 In RD0: EN_O=1, ADDR_O=2t.
REQ-021 In RD1: EN_O=1, ADDR_O=2t+1, and latch RDATA_O as the low half.
REQ-022 In CAP: EN_O=0, and latch RDATA_O as the high half.
REQ-023 In WR: EN_R=1, RW_R=1, ADDR_R=t, WDATA_R driven from registers.
REQ-024 After WR with t<7: increment t, then go to RD0 if the new t<T, otherwise go to WR.
REQ-025 After WR with t=7: go to DONE.
REQ-026 DONE SHALL be high for exactly one cycle, then the FSM returns to IDLE.
REQ-027 Latency: DONE SHALL assert 4*T+(8-T)+1 cycles after the START-sampling edge (T=3 gives 18; T=8 gives 33; T=0 gives 9).
REQ-028 Source layout: address 2t holds columns 1..4 in bits [63:48],[47:32],[31:16],[15:0]; address 2t+1 holds columns 5..8 in the same order; all values are signed 16-bit.
REQ-029 Per element x: r = (x<0) ? 0 : x; y = r >> SHIFT (logical).
REQ-030 If SAT_EN=1, byte = min(y,127); if SAT_EN=0, byte = y[7:0].
REQ-031 Output packing: column 1 in WDATA_R[63:56] through column 8 in WDATA_R[7:0].
REQ-032 Columns j>M SHALL be forced to 0x00.
REQ-033 Rows t>=T SHALL be written as all zeros with no OUT_MEM read.
REQ-034 START while not in IDLE SHALL be ignored.
REQ-035 START held high through DONE SHALL retrigger from IDLE on the following cycle.
REQ-036 EN_O and EN_R SHALL never be high in the same cycle.

Reset
REQ-037 RST=1 SHALL immediately force the following, regardless of state: IDLE, t=0, EN_O=0, EN_R=0, RW_R=0, ADDR_O=0, ADDR_R=0, WDATA_R=0, DONE=0, and latched fields and halves cleared.
REQ-038 Reset mid-operation SHALL abort the operation with no further memory access; the next START restarts from row 0.

Verification
REQ-039 MNT=0x373, SHIFT=0, addr0=0x0005_FFFF_0100_0000 -> row0 WDATA_R=0x05007F0000000000; rows 3..7 are 0; DONE at cycle 18.
REQ-040 SHIFT=4, M=8, element values 0x07F0 and 0x0123 -> bytes 0x7F and 0x12.
REQ-041 SAT_EN=0, SHIFT=0, element value 0x0100 -> byte 0x00; element value 0x8000 -> byte 0x00.
REQ-042 MNT=0x888 -> ADDR_O sequence 0..15 with no gaps, 8 writes to ADDR_R 0..7, DONE at cycle 33.
REQ-043 RST pulsed during row-2 RD1 -> EN_O and DONE are 0 in the same cycle and no WR follows; a new START rewrites from ADDR_R=0.
REQ-044 MNT=0x000 -> 8 all-zero writes with EN_O never asserted, DONE at cycle 9; a START pulse mid-run has no effect.
